// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state codes and stream framing constants for the imem boot loader
package imem_loader_pkg;

    // Stream framing: 2-byte little-endian word count, then 4 bytes per word
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Loader state codes
    typedef logic [2:0] state_t;
    localparam logic [2:0] HDR_LO = 3'd0;
    localparam logic [2:0] HDR_HI = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    // States in which the loader takes a byte from the stream
    function automatic logic state_accepts(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, imem write port and status bundle of the boot loader
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    // Loader side: consumes the byte stream, masters the imem write port
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_done, load_error
    );

    // Environment side: byte source, instruction memory and core control
    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian stream bytes into 32-bit words
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_full,
    output logic [31:0] o_word
);
    logic [1:0]  r_lane;
    logic [31:0] r_word;

    // Shift each byte in from the top so lane 0 ends up in bits [7:0]
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
        end else if (i_accept) begin
            r_word <= {i_byte, r_word[31:8]};
            r_lane <= r_lane + 2'd1;
        end
    end

    // Word completes in the cycle its lane-3 byte is accepted
    assign o_word_full = i_accept && (r_lane == 2'(BYTES_PER_WORD - 1));
    assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a length-prefixed byte stream into imem (option: LOADER_CHECKSUM_EN)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 16384
)(
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_count;
    logic [15:0]           r_word_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_accept;
    logic                  w_word_full;
    logic                  w_last_word;
    logic [15:0]           w_hdr_count;
    logic [31:0]           w_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_xsum;
`endif

    assign w_accept    = bus.byte_valid && bus.byte_ready;
    assign w_hdr_count = {bus.byte_data, r_count[7:0]};
    assign w_last_word = (r_word_idx == (r_count - 16'd1));

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_accept && (r_state == DATA)),
        .i_byte      (bus.byte_data),
        .o_word_full (w_word_full),
        .o_word      (w_word)
    );

    // Next-state decode for the header / payload / terminal sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_LO: if (w_accept) w_next = HDR_HI;
            HDR_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_hdr_count} > MAX_W)
                        w_next = ERROR;
                    else if (w_hdr_count == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        w_next = CHECK;
`else
                        w_next = DONE;
`endif
                    else
                        w_next = DATA;
                end
            end
            DATA:   if (w_word_full) w_next = WRITE;
            WRITE: begin
                if (w_last_word)
`ifdef LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = DONE;
`endif
                else
                    w_next = DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK:  if (w_accept) w_next = (bus.byte_data == r_xsum) ? DONE : ERROR;
`endif
            DONE:   w_next = DONE;
            ERROR:  w_next = ERROR;
            default: w_next = ERROR;
        endcase
    end

    // State register; DONE and ERROR are left only through rst
    always_ff @(posedge clk) begin
        if (rst) r_state <= HDR_LO;
        else     r_state <= w_next;
    end

    // Capture the word count from the two header bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (w_accept) begin
            if (r_state == HDR_LO) r_count[7:0]  <= bus.byte_data;
            if (r_state == HDR_HI) r_count[15:8] <= bus.byte_data;
        end
    end

    // Advance word index and write address after each non-final write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= BASE_ADDR;
            r_word_idx <= 16'd0;
        end else if ((r_state == WRITE) && !w_last_word) begin
            r_addr     <= r_addr + ADDR_WIDTH'(BYTES_PER_WORD);
            r_word_idx <= r_word_idx + 16'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every stream byte ahead of the checksum byte itself
    always_ff @(posedge clk) begin
        if (rst)                             r_xsum <= 8'd0;
        else if (w_accept && r_state != CHECK) r_xsum <= r_xsum ^ bus.byte_data;
    end
`endif

    assign bus.byte_ready = state_accepts(r_state);
    assign bus.imem_we    = (r_state == WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_word;
    assign bus.cpu_hold   = (r_state != DONE);
    assign bus.load_done  = (r_state == DONE);
    assign bus.load_error = (r_state == ERROR);

endmodule
